wb_commit_unit: RTL and testbench

Sink end of the MEM/WB writeback interface. Consumes the writeback bundle (GPR write, HI/LO write, LLbit write) each clock and commits it to architectural state: the 32x32 general register file, the HI/LO pair and the LLbit. Provides two GPR read ports to the decode stage, and HI/LO/LLbit read values to the execute and memory stages. Also keeps a running count of committed writebacks.

---
 rtl/wb_commit_unit.sv | 103 ++++++++++
 tb/tb_wb_commit_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// Writeback commit: GPR file, HI/LO, LLbit and retired-writeback counter.
// Optional macro WB_BYPASS_EN adds same-cycle write-through forwarding to all read outputs.
module wb_commit_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_whilo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              flush,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              LLbit_o,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              llbit_q, llbit_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic              gpr_we;
  logic              commit;

  always_comb begin
    gpr_we       = wb_wreg && (wb_wd != '0);
    commit       = gpr_we || wb_whilo || wb_LLbit_we;
    hi_d         = wb_whilo ? wb_hi : hi_q;
    lo_d         = wb_whilo ? wb_lo : lo_q;
    // flush kills a pending LL/SC reservation even if the same bundle sets it
    llbit_d      = flush ? 1'b0 : (wb_LLbit_we ? wb_LLbit_value : llbit_q);
    retire_cnt_d = commit ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      llbit_q      <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (gpr_we) gpr_q[wb_wd] <= wb_wdata;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      llbit_q      <= llbit_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst || raddr1 == '0 || !re1) rdata1 = '0;
`ifdef WB_BYPASS_EN
    else if (gpr_we && wb_wd == raddr1) rdata1 = wb_wdata;
`endif
    else rdata1 = gpr_q[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (rst || raddr2 == '0 || !re2) rdata2 = '0;
`ifdef WB_BYPASS_EN
    else if (gpr_we && wb_wd == raddr2) rdata2 = wb_wdata;
`endif
    else rdata2 = gpr_q[raddr2];
  end

  always_comb begin
    hi_o    = '0;
    lo_o    = '0;
    LLbit_o = 1'b0;
    if (!rst) begin
`ifdef WB_BYPASS_EN
      // the next-state values already encode the forwarding priorities
      hi_o    = hi_d;
      lo_o    = lo_d;
      LLbit_o = llbit_d;
`else
      hi_o    = hi_q;
      lo_o    = lo_q;
      LLbit_o = llbit_q;
`endif
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: stimulus queues expectations, a negedge monitor checks them.
module tb_wb_commit_unit;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int S_RD1 = 0, S_RD2 = 1, S_HI = 2, S_LO = 3, S_LL = 4, S_CNT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic [4:0]  wb_wd, raddr1, raddr2;
  logic        wb_wreg, wb_whilo, wb_LLbit_we, wb_LLbit_value, flush, re1, re2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o, retire_cnt;
  logic        LLbit_o;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  wb_commit_unit dut (
    .clk(clk), .rst(rst),
    .wb_wdata(wb_wdata), .wb_wd(wb_wd), .wb_wreg(wb_wreg),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .flush(flush),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // monitor: everything queued during a cycle is checked at the following negedge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        S_RD1:   act = rdata1;
        S_RD2:   act = rdata2;
        S_HI:    act = hi_o;
        S_LO:    act = lo_o;
        S_LL:    act = {31'd0, LLbit_o};
        default: act = retire_cnt;
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_wdata = '0; wb_wd = '0; wb_wreg = 0;
    wb_hi = '0; wb_lo = '0; wb_whilo = 0;
    wb_LLbit_we = 0; wb_LLbit_value = 0; flush = 0;
    re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    re1 = 1; raddr1 = a1; re2 = 1; raddr2 = a2;
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    // 1: reset forcing, even with a pending write to the read address
    rd(5'd1, 5'd31);
    wb_wreg = 1; wb_wd = 5'd1; wb_wdata = 32'hFFFF_FFFF; wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
    expect_val("rst_rd1", S_RD1, 0); expect_val("rst_rd2", S_RD2, 0);
    expect_val("rst_hi", S_HI, 0);   expect_val("rst_lo", S_LO, 0);
    tick();
    rst = 0; idle(); rd(5'd1, 5'd31);
    expect_val("post_rst_rd1", S_RD1, 0); expect_val("post_rst_rd2", S_RD2, 0);
    expect_val("post_rst_hi", S_HI, 0);   expect_val("post_rst_lo", S_LO, 0);
    expect_val("post_rst_ll", S_LL, 0);   expect_val("post_rst_cnt", S_CNT, 0);
    tick();

    // 2: GPR write and r0 discard
    idle(); wb_wreg = 1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF; re1 = 1; raddr1 = 5'd5;
    expect_val("r5_same_cycle", S_RD1, BYP ? 32'hDEAD_BEEF : 32'h0);
    tick();
    idle(); rd(5'd5, 5'd0);
    expect_val("r5_read", S_RD1, 32'hDEAD_BEEF); expect_val("r0_read", S_RD2, 0);
    expect_val("cnt_after_r5", S_CNT, 1);
    tick();
    idle(); wb_wreg = 1; wb_wd = 5'd0; wb_wdata = 32'h1234; rd(5'd0, 5'd5);
    expect_val("r0_write_same", S_RD1, 0);
    tick();
    idle(); rd(5'd0, 5'd5);
    expect_val("r0_after_write", S_RD1, 0); expect_val("r5_port2", S_RD2, 32'hDEAD_BEEF);
    expect_val("cnt_r0_discard", S_CNT, 1);
    tick();

    // 3: HI/LO
    idle(); wb_whilo = 1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_BBBB;
    expect_val("hi_same", S_HI, BYP ? 32'hAAAA_0000 : 32'h0);
    expect_val("lo_same", S_LO, BYP ? 32'h0000_BBBB : 32'h0);
    tick();
    idle();
    expect_val("hi_next", S_HI, 32'hAAAA_0000); expect_val("lo_next", S_LO, 32'h0000_BBBB);
    expect_val("cnt_hilo", S_CNT, 2);
    tick();

    // 4: LLbit with flush priority
    idle(); wb_LLbit_we = 1; wb_LLbit_value = 1; flush = 1;
    expect_val("ll_flush_we_same", S_LL, 0);
    tick();
    idle();
    expect_val("ll_flush_we_next", S_LL, 0); expect_val("cnt_ll_flush", S_CNT, 3);
    tick();
    idle(); wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_val("ll_set_same", S_LL, BYP ? 1 : 0);
    tick();
    idle();
    expect_val("ll_set_next", S_LL, 1); expect_val("cnt_ll_set", S_CNT, 4);
    tick();
    idle(); flush = 1;
    expect_val("ll_flush_same", S_LL, BYP ? 0 : 1);
    tick();
    idle();
    expect_val("ll_flush_next", S_LL, 0); expect_val("cnt_flush_only", S_CNT, 4);
    tick();

    // 5: write-through on r7, re gating, non-matching write
    idle(); wb_wreg = 1; wb_wd = 5'd7; wb_wdata = 32'h11;
    tick();
    idle(); wb_wreg = 1; wb_wd = 5'd7; wb_wdata = 32'h55;
    re1 = 1; raddr1 = 5'd7; re2 = 0; raddr2 = 5'd7;
    expect_val("r7_bypass", S_RD1, BYP ? 32'h55 : 32'h11);
    expect_val("r7_re_off", S_RD2, 0);
    expect_val("cnt_r7_first", S_CNT, 5);
    tick();
    idle(); wb_wreg = 1; wb_wd = 5'd8; wb_wdata = 32'h99; rd(5'd7, 5'd7);
    expect_val("r7_p1", S_RD1, 32'h55); expect_val("r7_p2", S_RD2, 32'h55);
    tick();
    idle(); wb_wd = 5'd7; wb_wdata = 32'hFFFF; rd(5'd8, 5'd7);
    expect_val("r8_read", S_RD1, 32'h99); expect_val("r7_no_we", S_RD2, 32'h55);
    tick();
    idle(); rd(5'd7, 5'd8);
    expect_val("r7_hold", S_RD1, 32'h55); expect_val("cnt_bubble", S_CNT, 7);
    tick();

    // 6: counter wrap with all enables set, then mid-stream reset
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    idle();
    wb_wreg = 1; wb_wd = 5'd3; wb_wdata = 32'h3;
    wb_whilo = 1; wb_hi = 32'h1; wb_lo = 32'h2;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_val("cnt_pre_wrap", S_CNT, 32'hFFFF_FFFF);
    tick();
    idle(); rd(5'd3, 5'd7);
    expect_val("cnt_wrap", S_CNT, 0); expect_val("r3_wrap", S_RD1, 32'h3);
    expect_val("hi_wrap", S_HI, 32'h1); expect_val("lo_wrap", S_LO, 32'h2);
    expect_val("ll_wrap", S_LL, 1);
    tick();
    rst = 1; idle(); rd(5'd3, 5'd7); wb_wreg = 1; wb_wd = 5'd9; wb_wdata = 32'h77;
    expect_val("rst_mid_rd1", S_RD1, 0); expect_val("rst_mid_ll", S_LL, 0);
    expect_val("rst_mid_hi", S_HI, 0);
    tick();
    rst = 0; idle(); rd(5'd3, 5'd7);
    expect_val("after_rst_r3", S_RD1, 0); expect_val("after_rst_r7", S_RD2, 0);
    expect_val("after_rst_hi", S_HI, 0);  expect_val("after_rst_lo", S_LO, 0);
    expect_val("after_rst_ll", S_LL, 0);  expect_val("after_rst_cnt", S_CNT, 0);
    tick();
    idle(); rd(5'd9, 5'd5);
    expect_val("after_rst_r9", S_RD1, 0); expect_val("after_rst_r5", S_RD2, 0);
    tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
